pe_compare_arbiter: RTL and testbench
=====================================

# pe_compare_arbiter

Round-robin arbiter and sequencer that shares one registered comparator (less-than, less-or-equal, equal) between `NUM_REQ` requesters inside the PE tile. It accepts one compare request at a time over per-requester valid/ready handshakes and latches the operands. It evaluates the selected comparison in a dedicated cycle, then holds a tagged 1-bit result on a single response channel until the response is consumed. It sits between the PE operand routing and the compare datapath, so that one compare unit serves several consumers.

## Interface
- `NUM_REQ`, 4: number of requesters; ≥2, power of two not required.
- `DATA_WIDTH`, 8: operand width in bits; ≥2.
- `ID_WIDTH`, 2: width of `rsp_id`; must satisfy 2^ID_WIDTH ≥ NUM_REQ.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant/accept, combinational from state and `req_valid`.
- `req_op`  in  2*NUM_REQ  opcode per requester, slice [2i+1:2i]:
  - 00 = lt
  - 01 = le
  - 10 = eq
  - 11 = reserved
- `req_signed`  in  NUM_REQ  1 = both operands are two's complement; 0 = unsigned.
- `req_a`, `req_b`  in  DATA_WIDTH*NUM_REQ  operands, slice [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i].
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_WIDTH  index of the requester this response belongs to.
- `rsp_result`  out  1  comparison result.
- `rsp_err`  out  1  the opcode was reserved (11).
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - EVAL: comparator cycle.
  - RESP: response held.
- IDLE:
  - If any `req_valid` is high, select the first set bit scanning upward from `rr_ptr` with wrap-around.
  - Assert `req_ready` only for that bit, in the same cycle.
  - On the clock edge, latch op, signed flag, a, b and the grant index; go to EVAL.
  - With no request, stay in IDLE and drive `req_ready` all zero.
- EVAL:
  - Compute the comparison on the latched operands and register `rsp_result`, `rsp_err` and `rsp_id`; go to RESP.
  - `req_ready` is all zero.
- RESP:
  - `rsp_valid`=1. `rsp_result`, `rsp_err` and `rsp_id` stay stable until `rsp_valid && rsp_ready`.
  - On that handshake go to IDLE and set `rr_ptr` = (grant index + 1) mod NUM_REQ.
  - `req_ready` is all zero.
- Arithmetic:
  - lt: A<B.
  - le: A≤B.
  - eq: A==B, sign-independent.
  - The signed flag selects a signed or unsigned interpretation of the full DATA_WIDTH operands; there is no sign extension or truncation.
  - Opcode 11: result 0, `rsp_err`=1. For every valid opcode `rsp_err`=0.
- The `req_*` inputs of a requester that is not granted are ignored. Deasserting `req_valid` without a handshake carries no obligation.
- Requesters see no buffering: each requester holds its request until its own `req_ready` is seen.

## Timing
- Reset values, asynchronous on `rst_n`=0:
  - state=IDLE, `rr_ptr`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_err`=0, `busy`=0.
- Latency from request acceptance (cycle T) to `rsp_valid` high is 2 cycles: EVAL at T+1, RESP at T+2.
- Minimum transaction period is 3 cycles when `rsp_ready` is held high: accept, eval, resp.
- IDLE is revisited for at least one cycle between transactions, so requests are never accepted back to back.
- Reset asserted mid-operation, in EVAL or RESP:
  - The transaction is dropped and no response is produced.
  - All outputs return to their reset values immediately.
  - After release the first grant starts from requester 0.
- `rsp_ready` high outside RESP has no effect.
- A `req_valid` rising during EVAL or RESP waits; it is arbitrated at the next IDLE cycle using the updated `rr_ptr`.
- Fairness: under continuous requests from all requesters, each requester is served exactly once in every NUM_REQ consecutive transactions.

## Test plan
- Reset, then req0 unsigned lt with a=3, b=5 and `rsp_ready`=1:
  - `req_ready`=0001 in the accept cycle.
  - `rsp_valid` at +2 cycles with `rsp_id`=0, `rsp_result`=1, `rsp_err`=0.
- req1 signed lt with a=8'hFF, b=8'h01 → result 1. The same request unsigned → result 0.
- le and eq checks:
  - le with a=b=8'h80 → 1.
  - eq with a=8'h10, b=8'h11 → 0.
  - Opcode 11 → `rsp_result`=0, `rsp_err`=1.
- All four requesters hold `req_valid` continuously with `rsp_ready`=1:
  - Grants are issued in the order 0,1,2,3,0.
  - `rsp_id` follows the same order.
  - The transactions are spaced exactly 3 cycles apart.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP:
  - `rsp_valid`, `rsp_id` and `rsp_result` stay stable.
  - No `req_ready` is asserted.
  - After `rsp_ready`=1 there is one IDLE cycle before the next grant.
- Pull `rst_n` low during EVAL of a req2 transaction, then release with req2 and req3 both valid:
  - No response appears for the dropped transaction.
  - All outputs go to 0 asynchronously.
  - After release the first grant goes to req2, since the scan starts at `rr_ptr`=0.

Source files
------------

// File: rtl/pe_compare_arbiter_if.sv
// Request/response bundle between PE operand routing (master) and the shared
// compare arbiter (slave).
interface pe_compare_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [2*NUM_REQ-1:0]          req_op;
  logic [NUM_REQ-1:0]            req_signed;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_a;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic                          rsp_result;
  logic                          rsp_err;

  modport master (
    output req_valid, req_op, req_signed, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_signed, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/pe_compare_arbiter.sv
// Round-robin arbiter sharing one registered lt/le/eq comparator among NUM_REQ
// requesters: accept -> evaluate -> hold tagged response until consumed.
module pe_compare_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pe_compare_arbiter_if.slave   bus,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t                  state, state_nxt;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [ID_WIDTH-1:0]     gnt_idx;
  logic                    gnt_found;

  logic [1:0]              sel_op;
  logic                    sel_sgn;
  logic [DATA_WIDTH-1:0]   sel_a, sel_b;

  logic [ID_WIDTH-1:0]     gnt_id_p0;
  logic [1:0]              op_p0;
  logic                    sgn_p0;
  logic [DATA_WIDTH-1:0]   a_p0, b_p0;

  // Returns {err, result}; eq ignores the signed flag, reserved opcode flags err.
  function automatic logic [1:0] compare_fn(
    input logic [1:0]            op,
    input logic                  sgn,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH-1:0] sa, sb;
    logic lt, eq;
    sa = a;
    sb = b;
    eq = (a == b);
    lt = sgn ? (sa < sb) : (a < b);
    case (op)
      2'b00:   return {1'b0, lt};
      2'b01:   return {1'b0, lt | eq};
      2'b10:   return {1'b0, eq};
      default: return 2'b10;
    endcase
  endfunction

  // First valid requester scanning upward from rr_ptr with wrap-around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!gnt_found && bus.req_valid[j] && ((int'(rr_ptr) + off) % NUM_REQ) == j) begin
          gnt_found = 1'b1;
          gnt_idx   = ID_WIDTH'(j);
        end
      end
    end
  end

  always_comb begin
    sel_op  = '0;
    sel_sgn = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_WIDTH'(i)) begin
        sel_op  = bus.req_op[2*i +: 2];
        sel_sgn = bus.req_signed[i];
        sel_a   = bus.req_a[DATA_WIDTH*i +: DATA_WIDTH];
        sel_b   = bus.req_b[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so it reads zero while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state == IDLE && gnt_found) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (gnt_idx == ID_WIDTH'(j)) bus.req_ready[j] = 1'b1;
      end
    end
    bus.rsp_valid = (state == RESP);
    busy          = (state != IDLE);
  end

  // ---- p0: operands latched at accept
  always_ff @(posedge clk) begin
    if (state == IDLE && gnt_found) begin
      gnt_id_p0 <= gnt_idx;
      op_p0     <= sel_op;
      sgn_p0    <= sel_sgn;
      a_p0      <= sel_a;
      b_p0      <= sel_b;
    end
  end

  // ---- p1: comparator result registered in EVAL, held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_id     <= '0;
      bus.rsp_result <= 1'b0;
      bus.rsp_err    <= 1'b0;
      rr_ptr         <= '0;
    end else begin
      if (state == EVAL) begin
        bus.rsp_id                     <= gnt_id_p0;
        {bus.rsp_err, bus.rsp_result}  <= compare_fn(op_p0, sgn_p0, a_p0, b_p0);
      end
      if (state == RESP && bus.rsp_ready) begin
        rr_ptr <= (gnt_id_p0 == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id_p0 + ID_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_compare_arbiter.sv
// Bench for pe_compare_arbiter: transaction-level model checked every cycle
// plus directed transactions with hand-computed results.
module tb_pe_compare_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  pe_compare_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus();

  pe_compare_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference comparison from the arithmetic rules, using plain integers.
  function automatic logic [1:0] model_cmp(input logic [1:0] op, input logic sgn,
                                           input logic [7:0] a, input logic [7:0] b);
    int va, vb;
    va = sgn ? int'($signed(a)) : int'(a);
    vb = sgn ? int'($signed(b)) : int'(b);
    case (op)
      2'd0:    return {1'b0, 1'(va < vb)};
      2'd1:    return {1'b0, 1'(va <= vb)};
      2'd2:    return {1'b0, 1'(a == b)};
      default: return 2'b10;
    endcase
  endfunction

  // Model: phase 0 idle, 1 evaluating, 2 response held.
  int            m_phase = 0;
  int            m_ptr   = 0;
  int            p_id    = 0;
  logic [1:0]    p_cmp   = 2'b00;
  logic [IW-1:0] m_id    = '0;
  logic          m_res   = 1'b0;
  logic          m_err   = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0]    exp_rdy;
    logic [N+IW+3:0] act_v, exp_v;
    int              g;
    exp_rdy = '0;
    g       = -1;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_id = '0; m_res = 1'b0; m_err = 1'b0;
    end else if (m_phase == 0) begin
      for (int off = 0; off < N; off++) begin
        int j;
        j = (m_ptr + off) % N;
        if (g < 0 && ((bus.req_valid >> j) & N'(1)) != '0) begin
          g = j;
          exp_rdy = N'(1) << j;
        end
      end
    end
    exp_v = {exp_rdy, 1'(m_phase == 2), m_id, m_res, m_err, 1'(m_phase != 0), 1'b0};
    act_v = {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err, busy, 1'b0};
    check("model", 32'(act_v), 32'(exp_v));
    if (rst_n) begin
      case (m_phase)
        0: if (g >= 0) begin
             p_id    = g;
             p_cmp   = model_cmp(2'(bus.req_op >> (2*g)), 1'(bus.req_signed >> g),
                                 8'(bus.req_a >> (8*g)), 8'(bus.req_b >> (8*g)));
             m_phase = 1;
           end
        1: begin
             m_id = IW'(p_id);
             {m_err, m_res} = p_cmp;
             m_phase = 2;
           end
        default: if (bus.rsp_ready) begin
             m_phase = 0;
             m_ptr   = (p_id + 1) % N;
           end
      endcase
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic sgn,
                         input logic [7:0] a, input logic [7:0] b);
    bus.req_op     = (bus.req_op & ~(8'h03 << (2*i))) | (8'(op) << (2*i));
    bus.req_signed = (bus.req_signed & ~(N'(1) << i)) | (N'(sgn) << i);
    bus.req_a      = (bus.req_a & ~(32'hFF << (8*i))) | (32'(a) << (8*i));
    bus.req_b      = (bus.req_b & ~(32'hFF << (8*i))) | (32'(b) << (8*i));
    bus.req_valid  = bus.req_valid | (N'(1) << i);
  endtask

  task automatic clr_req(input int i);
    bus.req_valid = bus.req_valid & ~(N'(1) << i);
  endtask

  task automatic wait_grant(input int i, input string name, output int gcyc);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready != '0) break;
    end
    gcyc = cyc;
    if (k == 20) begin
      checks++; errors++;
      $display("FAIL %s grant: got none expected req_ready bit %0d", name, i);
    end else begin
      check({name, " grant"}, 32'(bus.req_ready), 32'(N'(1) << i));
    end
  endtask

  task automatic wait_rsp(input int gcyc, input int id, input logic res, input logic err,
                          input string name);
    int k;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    if (k == 10) begin
      checks++; errors++;
      $display("FAIL %s rsp: got no rsp_valid expected one", name);
    end else begin
      check({name, " latency"}, 32'(cyc - gcyc), 32'd2);
      check({name, " rsp_id"},  32'(bus.rsp_id), 32'(id));
      check({name, " result"},  32'(bus.rsp_result), 32'(res));
      check({name, " err"},     32'(bus.rsp_err), 32'(err));
    end
  endtask

  task automatic do_txn(input int i, input logic [1:0] op, input logic sgn,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic res, input logic err, input string name);
    int g;
    @(posedge clk); #1;
    set_req(i, op, sgn, a, b);
    wait_grant(i, name, g);
    @(posedge clk); #1;
    clr_req(i);
    wait_rsp(g, i, res, err, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int g, prev, h;
    bus.req_valid = '0; bus.req_op = '0; bus.req_signed = '0;
    bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_txn(0, 2'b00, 1'b0, 8'h03, 8'h05, 1'b1, 1'b0, "lt_u");
    do_txn(1, 2'b00, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, "lt_s");
    do_txn(1, 2'b00, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "lt_u_ff");
    do_txn(2, 2'b01, 1'b0, 8'h80, 8'h80, 1'b1, 1'b0, "le_same");
    do_txn(3, 2'b10, 1'b0, 8'h10, 8'h11, 1'b0, 1'b0, "eq_ne");
    do_txn(0, 2'b11, 1'b0, 8'h12, 8'h34, 1'b0, 1'b1, "op_rsv");
    do_txn(3, 2'b01, 1'b1, 8'h80, 8'h7F, 1'b1, 1'b0, "le_s");

    // All four requesting continuously; rr_ptr is back at 0 here.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 1'b0, 8'(i), 8'd2);
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(n % N, "rr", g);
      if (n > 0) check("rr spacing", 32'(g - prev), 32'd3);
      prev = g;
      if (n == 4) begin
        @(posedge clk); #1;
        bus.req_valid = '0;
      end
      wait_rsp(g, n % N, 1'((n % N) < 2), 1'b0, "rr");
    end

    // Backpressure on req1 with req2 arriving while the response is held.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_req(1, 2'b10, 1'b0, 8'h42, 8'h42);
    wait_grant(1, "bp", g);
    @(posedge clk); #1;
    clr_req(1);
    wait_rsp(g, 1, 1'b1, 1'b0, "bp");
    @(posedge clk); #1;
    set_req(2, 2'b00, 1'b0, 8'h01, 8'h02);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp hold", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready}),
            32'({1'b1, 2'd1, 1'b1, 4'b0000}));
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    h = cyc;
    wait_grant(2, "bp next", g);
    check("bp idle gap", 32'(g - h), 32'd1);

    // Reset during EVAL of req2; the dropped lt would have answered 1.
    @(posedge clk); #1;
    clr_req(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst", 32'({busy, bus.rsp_valid, bus.req_ready}), 32'd0);
    set_req(2, 2'b10, 1'b0, 8'h01, 8'h02);
    set_req(3, 2'b01, 1'b0, 8'h04, 8'h05);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_grant(2, "post rst", g);
    @(posedge clk); #1;
    clr_req(2);
    wait_rsp(g, 2, 1'b0, 1'b0, "post rst");
    wait_grant(3, "post rst r3", g);
    @(posedge clk); #1;
    clr_req(3);
    wait_rsp(g, 3, 1'b1, 1'b0, "post rst r3");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
